// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer: opcode and state encodings, the flag
// bundle, and the binary ALU evaluation function.
package alu_seq_pkg;

    localparam int OP_LAST = 11;

    typedef enum logic [3:0] {
        OP_ADC  = 4'd0,
        OP_SBC  = 4'd1,
        OP_AND  = 4'd2,
        OP_ORA  = 4'd3,
        OP_EOR  = 4'd4,
        OP_CMP  = 4'd5,
        OP_ASL  = 4'd6,
        OP_LSR  = 4'd7,
        OP_ROL  = 4'd8,
        OP_ROR  = 4'd9,
        OP_INC  = 4'd10,
        OP_DEC  = 4'd11,
        OP_PASS = 4'd12
    } alu_op_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_ACC = 3'd1,
        LOAD_DB  = 3'd2,
        EXEC     = 3'd3,
        DADJ     = 3'd4,
        RESP     = 3'd5
    } seq_state_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    typedef struct packed {
        logic [7:0] result;
        alu_flags_t flags;
    } alu_out_t;

    function automatic alu_out_t alu_exec(input alu_op_e op, input logic [7:0] a,
                                          input logic [7:0] b, input logic c_in);
        alu_out_t   o;
        logic [8:0] sum;
        logic [7:0] b_eff;
        o       = '0;
        o.flags.c = c_in;
        sum     = '0;
        b_eff   = (op == OP_SBC) ? ~b : b;
        case (op)
            OP_ADC, OP_SBC: begin
                sum       = {1'b0, a} + {1'b0, b_eff} + {8'd0, c_in};
                o.result  = sum[7:0];
                o.flags.c = sum[8];
                o.flags.v = (a[7] == b_eff[7]) && (sum[7] != a[7]);
            end
            OP_AND: o.result = a & b;
            OP_ORA: o.result = a | b;
            OP_EOR: o.result = a ^ b;
            OP_CMP: begin
                sum       = {1'b0, a} + {1'b0, ~b} + 9'd1;
                o.result  = sum[7:0];
                o.flags.c = sum[8];
            end
            OP_ASL: {o.flags.c, o.result} = {a, 1'b0};
            OP_LSR: {o.result, o.flags.c} = {1'b0, a};
            OP_ROL: {o.flags.c, o.result} = {a, c_in};
            OP_ROR: {o.result, o.flags.c} = {c_in, a};
            OP_INC: o.result = a + 8'd1;
            OP_DEC: o.result = a - 8'd1;
            default: o.result = a;
        endcase
        o.flags.n = o.result[7];
        o.flags.z = (o.result == 8'd0);
        return o;
    endfunction

endpackage

// File: rtl/bcd_adjust.sv
// Decimal correction for ADC/SBC; recomputes the binary sum from the
// captured operands and applies the nibble corrections.
module bcd_adjust (
    input  logic       is_sub,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c_in,
    output logic [7:0] result,
    output logic       carry
);
    logic [7:0] b_eff;
    logic [4:0] lo_sum;
    logic [8:0] bin_sum;
    logic [8:0] adj;

    always_comb begin
        b_eff   = is_sub ? ~b : b;
        lo_sum  = {1'b0, a[3:0]} + {1'b0, b_eff[3:0]} + {4'd0, c_in};
        bin_sum = {1'b0, a} + {1'b0, b_eff} + {8'd0, c_in};
        adj     = bin_sum;
        carry   = bin_sum[8];
        if (!is_sub) begin
            if (bin_sum[3:0] > 4'd9 || lo_sum[4])
                adj = adj + 9'h006;
            // high check uses the low-corrected value so a 0x9A-style sum rolls over
            if (adj > 9'h09F || bin_sum[8]) begin
                adj   = adj + 9'h060;
                carry = 1'b1;
            end
        end else begin
            if (!lo_sum[4])
                adj = adj - 9'h006;
            if (!bin_sum[8])
                adj = adj - 9'h060;
        end
        result = adj[7:0];
    end
endmodule

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation per request through acc/db load strobes and a
// compute step. Optional decimal adjust enabled by defining ALU_DECIMAL_EN.
//
// state    | meaning
// IDLE     | req_ready high, waiting for a request
// LOAD_ACC | acc_to_alu_xfer strobe, captured A on alu_acc_data
// LOAD_DB  | instruction_decode_in strobe, captured B on alu_db_data
// EXEC     | compute_step strobe, binary result/flags registered
// DADJ     | decimal correction of ADC/SBC result
// RESP     | rsp_valid held until rsp_ready
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OP_W-1:0] req_op,
    input  logic [7:0]      req_a,
    input  logic [7:0]      req_b,
    input  logic            req_c,
    input  logic            req_d,
    output logic            acc_to_alu_xfer,
    output logic            instruction_decode_in,
    output logic            compute_step,
    output logic [7:0]      alu_acc_data,
    output logic [7:0]      alu_db_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [7:0]      rsp_result,
    output logic            rsp_n,
    output logic            rsp_z,
    output logic            rsp_c,
    output logic            rsp_v
);
    seq_state_e      state;
    logic [OP_W-1:0] op_q;
    logic [7:0]      a_q;
    logic [7:0]      b_q;
    logic            c_q;
    alu_op_e         op_sel;
    alu_out_t        alu_o;
    alu_flags_t      rsp_flags;
    logic            dec_apply;
    logic [7:0]      bcd_result;
    logic            bcd_carry;

    assign req_ready = (state == IDLE) && !reset;
    assign rsp_n = rsp_flags.n;
    assign rsp_z = rsp_flags.z;
    assign rsp_c = rsp_flags.c;
    assign rsp_v = rsp_flags.v;

    // Opcodes above the defined set (including wide OP_W values) pass A through.
    always_comb begin
        op_sel = OP_PASS;
        if (op_q <= OP_W'(OP_LAST))
            op_sel = alu_op_e'(op_q[3:0]);
        alu_o = alu_exec(op_sel, a_q, b_q, c_q);
    end

`ifdef ALU_DECIMAL_EN
    logic d_q;

    always_ff @(posedge clk) begin
        if (reset)
            d_q <= 1'b0;
        else if (req_valid && state == IDLE)
            d_q <= req_d;
    end

    assign dec_apply = d_q && (op_sel == OP_ADC || op_sel == OP_SBC);

    bcd_adjust u_bcd_adjust (
        .is_sub (op_sel == OP_SBC),
        .a      (a_q),
        .b      (b_q),
        .c_in   (c_q),
        .result (bcd_result),
        .carry  (bcd_carry)
    );
`else
    logic unused_req_d;

    assign unused_req_d = req_d;
    assign dec_apply    = 1'b0;
    assign bcd_result   = alu_o.result;
    assign bcd_carry    = alu_o.flags.c;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= IDLE;
            op_q                  <= '0;
            a_q                   <= 8'd0;
            b_q                   <= 8'd0;
            c_q                   <= 1'b0;
            acc_to_alu_xfer       <= 1'b0;
            instruction_decode_in <= 1'b0;
            compute_step          <= 1'b0;
            alu_acc_data          <= 8'd0;
            alu_db_data           <= 8'd0;
            rsp_valid             <= 1'b0;
            rsp_result            <= 8'd0;
            rsp_flags             <= '0;
        end else begin
            acc_to_alu_xfer       <= 1'b0;
            instruction_decode_in <= 1'b0;
            compute_step          <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q            <= req_op;
                        a_q             <= req_a;
                        b_q             <= req_b;
                        c_q             <= req_c;
                        alu_acc_data    <= req_a;
                        acc_to_alu_xfer <= 1'b1;
                        state           <= LOAD_ACC;
                    end
                end
                LOAD_ACC: begin
                    alu_db_data           <= b_q;
                    instruction_decode_in <= 1'b1;
                    state                 <= LOAD_DB;
                end
                LOAD_DB: begin
                    compute_step <= 1'b1;
                    state        <= EXEC;
                end
                EXEC: begin
                    rsp_result <= alu_o.result;
                    rsp_flags  <= alu_o.flags;
                    if (dec_apply) begin
                        state <= DADJ;
                    end else begin
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                DADJ: begin
                    // V keeps the binary overflow captured in EXEC
                    rsp_result  <= bcd_result;
                    rsp_flags.n <= bcd_result[7];
                    rsp_flags.z <= (bcd_result == 8'd0);
                    rsp_flags.c <= bcd_carry;
                    rsp_valid   <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: driver pushes expected responses,
// monitor pops and compares whenever rsp_valid is presented.
module tb_alu_sequencer;
    localparam int OP_W = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [OP_W-1:0] req_op;
    logic [7:0]      req_a;
    logic [7:0]      req_b;
    logic            req_c;
    logic            req_d;
    logic            acc_to_alu_xfer;
    logic            instruction_decode_in;
    logic            compute_step;
    logic [7:0]      alu_acc_data;
    logic [7:0]      alu_db_data;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [7:0]      rsp_result;
    logic            rsp_n;
    logic            rsp_z;
    logic            rsp_c;
    logic            rsp_v;

    alu_sequencer #(.OP_W(OP_W)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_op                (req_op),
        .req_a                 (req_a),
        .req_b                 (req_b),
        .req_c                 (req_c),
        .req_d                 (req_d),
        .acc_to_alu_xfer       (acc_to_alu_xfer),
        .instruction_decode_in (instruction_decode_in),
        .compute_step          (compute_step),
        .alu_acc_data          (alu_acc_data),
        .alu_db_data           (alu_db_data),
        .rsp_valid             (rsp_valid),
        .rsp_ready             (rsp_ready),
        .rsp_result            (rsp_result),
        .rsp_n                 (rsp_n),
        .rsp_z                 (rsp_z),
        .rsp_c                 (rsp_c),
        .rsp_v                 (rsp_v)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] r;
        logic [3:0] f;   // {n,z,c,v}
        int         lat;
        int         hold;
        int         acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic d, input logic [7:0] r, input logic [3:0] f,
                        input int lat, input int hold, input bit strobes);
        exp_t e;
        int   waited = 0;
        @(negedge clk);
        req_op = op; req_a = a; req_b = b; req_c = c; req_d = d; req_valid = 1'b1;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        e.r = r; e.f = f; e.lat = lat; e.hold = hold; e.acc = cyc;
        exp_q.push_back(e);
        @(posedge clk); #1;
        // scramble request inputs: the captured copy must be used
        req_valid = 1'b0; req_a = ~a; req_b = ~b; req_c = ~c; req_d = ~d; req_op = op ^ 4'h5;
        if (strobes) begin
            check("acc_xfer_on", 32'(acc_to_alu_xfer), 32'd1);
            check("acc_data", 32'(alu_acc_data), 32'(a));
            check("decode_early", 32'(instruction_decode_in), 32'd0);
            @(posedge clk); #1;
            check("acc_xfer_off", 32'(acc_to_alu_xfer), 32'd0);
            check("decode_on", 32'(instruction_decode_in), 32'd1);
            check("db_data", 32'(alu_db_data), 32'(b));
            @(posedge clk); #1;
            check("decode_off", 32'(instruction_decode_in), 32'd0);
            check("compute_on", 32'(compute_step), 32'd1);
        end
    endtask

    // monitor / scoreboard
    initial begin
        exp_t e;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid && !reset) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                    rsp_ready = 1'b1;
                    @(posedge clk); #1;
                    rsp_ready = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                    check("result", 32'(rsp_result), 32'(e.r));
                    check("flags_nzcv", 32'({rsp_n, rsp_z, rsp_c, rsp_v}), 32'(e.f));
                    check("latency", 32'(cyc - e.acc), 32'(e.lat));
                    for (int h = 0; h < e.hold; h++) begin
                        @(negedge clk);
                        check("hold_valid", 32'(rsp_valid), 32'd1);
                        check("hold_result", 32'(rsp_result), 32'(e.r));
                        check("hold_flags", 32'({rsp_n, rsp_z, rsp_c, rsp_v}), 32'(e.f));
                        check("hold_req_ready", 32'(req_ready), 32'd0);
                    end
                    rsp_ready = 1'b1;
                    @(posedge clk); #1;
                    rsp_ready = 1'b0;
                    check("valid_after_hs", 32'(rsp_valid), 32'd0);
                    if (e.hold > 0)
                        check("idle_after_hs", 32'(req_ready), 32'd1);
                end
            end
        end
    end

    initial begin
        int w;
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = 8'd0; req_b = 8'd0;
        req_c = 1'b0; req_d = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_result", 32'(rsp_result), 32'd0);
        check("rst_strobes", 32'({acc_to_alu_xfer, instruction_decode_in, compute_step}), 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", 32'(req_ready), 32'd1);

        //   op     a      b      c     d     result flags(nzcv) lat hold strobes
        send(4'd0,  8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 4'b1001, 4, 0, 1'b1);
`ifdef ALU_DECIMAL_EN
        send(4'd0,  8'h19, 8'h28, 1'b1, 1'b1, 8'h48, 4'b0000, 5, 0, 1'b0);
        send(4'd1,  8'h00, 8'h01, 1'b1, 1'b1, 8'h99, 4'b1000, 5, 0, 1'b0);
        send(4'd0,  8'h99, 8'h01, 1'b0, 1'b1, 8'h00, 4'b0110, 5, 0, 1'b0);
`else
        send(4'd0,  8'h19, 8'h28, 1'b1, 1'b1, 8'h42, 4'b0000, 4, 0, 1'b0);
        send(4'd1,  8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 4'b1000, 4, 0, 1'b0);
        send(4'd0,  8'h99, 8'h01, 1'b0, 1'b1, 8'h9A, 4'b1000, 4, 0, 1'b0);
`endif
        send(4'd5,  8'h10, 8'h10, 1'b0, 1'b0, 8'h00, 4'b0110, 4, 0, 1'b0);
        send(4'd9,  8'h01, 8'h00, 1'b1, 1'b0, 8'h80, 4'b1010, 4, 3, 1'b0);
        send(4'd1,  8'h50, 8'h10, 1'b1, 1'b0, 8'h40, 4'b0010, 4, 0, 1'b0);
        send(4'd2,  8'hF0, 8'h3C, 1'b1, 1'b0, 8'h30, 4'b0010, 4, 0, 1'b0);
        send(4'd3,  8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0100, 4, 0, 1'b0);
        send(4'd4,  8'hFF, 8'h0F, 1'b0, 1'b0, 8'hF0, 4'b1000, 4, 1, 1'b0);
        send(4'd6,  8'h81, 8'h00, 1'b0, 1'b0, 8'h02, 4'b0010, 4, 0, 1'b0);
        send(4'd7,  8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0110, 4, 0, 1'b0);
        send(4'd8,  8'h80, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0110, 4, 0, 1'b0);
        send(4'd10, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0100, 4, 0, 1'b0);
        send(4'd11, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 4'b1010, 4, 0, 1'b0);
        send(4'd13, 8'h7F, 8'h55, 1'b1, 1'b0, 8'h7F, 4'b0010, 4, 0, 1'b0);
        send(4'd0,  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 4'b1001, 4, 0, 1'b0);

        w = 0;
        while ((exp_q.size() != 0 || rsp_valid) && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);

        // reset on the EXEC cycle discards the operation
        @(negedge clk);
        req_op = 4'd0; req_a = 8'h11; req_b = 8'h22; req_c = 1'b0; req_d = 1'b0;
        check("rst_seq_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("exec_compute", 32'(compute_step), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_strobes", 32'({acc_to_alu_xfer, instruction_decode_in, compute_step}), 32'd0);
        check("midrst_valid", 32'(rsp_valid), 32'd0);
        check("midrst_result", 32'(rsp_result), 32'd0);
        check("midrst_flags", 32'({rsp_n, rsp_z, rsp_c, rsp_v}), 32'd0);
        check("midrst_acc_data", 32'(alu_acc_data), 32'd0);
        check("midrst_db_data", 32'(alu_db_data), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("postrst_ready", 32'(req_ready), 32'd1);
        repeat (8) @(negedge clk);
        check("no_rsp_after_rst", 32'(rsp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
